// File: rtl/mem_stage_access_pkg.sv
// Shared types for the MEM-stage data-memory access unit.
// FSM state encoding, writeback-select codes, alignment helper.
package mem_stage_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  function automatic logic misaligned(
    input logic       access,
    input logic [1:0] lo
  );
    return access & (lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory req/ack bus between the MEM stage and memory.
// master = MEM stage, slave = memory.
interface mem_stage_access_if #(
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_stage_access_mem_wb.sv
// MEM/WB pipeline register.
// A stall turns the slot into a bubble by clearing RegWrite only.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] memdata_i,
  input  logic [4:0]        wa_i,
  input  logic [1:0]        mtr_i,
  input  logic              regwrite_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] memdata_o,
  output logic [4:0]        wa_o,
  output logic [1:0]        mtr_o,
  output logic              regwrite_o
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] memdata_q;
  logic [4:0]        wa_q;
  logic [1:0]        mtr_q;
  logic              regwrite_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      alu_q      <= '0;
      memdata_q  <= '0;
      wa_q       <= '0;
      mtr_q      <= '0;
      regwrite_q <= 1'b0;
    end else if (stall_i) begin
      regwrite_q <= 1'b0;
    end else begin
      pc_q       <= pc_i;
      alu_q      <= alu_i;
      memdata_q  <= memdata_i;
      wa_q       <= wa_i;
      mtr_q      <= mtr_i;
      regwrite_q <= regwrite_i;
    end
  end

  assign pc_o       = pc_q;
  assign alu_o      = alu_q;
  assign memdata_o  = memdata_q;
  assign wa_o       = wa_q;
  assign mtr_o      = mtr_q;
  assign regwrite_o = regwrite_q;

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: EX/MEM fields to a req/ack data-memory transaction,
// upstream stall while memory is busy, MEM/WB register write.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MEM_PC,
  input  logic [DATA_W-1:0] MEM_ALUOut,
  input  logic [DATA_W-1:0] MEM_ReadData_2,
  input  logic [4:0]        MEM_Write_Address,
  input  logic [1:0]        MEM_MemtoReg,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemRead,
  input  logic              MEM_RegWrite,
  mem_stage_access_if.master dmem,
  output logic              mem_stall,
  output logic [DATA_W-1:0] WB_PC,
  output logic [DATA_W-1:0] WB_ALUOut,
  output logic [DATA_W-1:0] WB_MemData,
  output logic [4:0]        WB_Write_Address,
  output logic [1:0]        WB_MemtoReg,
  output logic              WB_RegWrite,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic [31:0]       stall_cycles
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_mis_q;
  logic [31:0]       stall_cnt_q;

  logic              access;
  logic              misal;
  logic              req;
  logic              stall;
  logic              rd_ack;
  logic [DATA_W-1:0] memdata;

  assign access = MEM_MemRead | MEM_MemWrite;
  assign misal  = misaligned(access, MEM_ALUOut[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access && !misal) begin
          req = 1'b1;
          if (!dmem.ack) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem.ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_mis_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_mis_q <= misal && (state_q == S_IDLE);
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // Read and write both set resolves to a write, so a read ack
  // only counts when no store is in flight.
  assign rd_ack  = req & dmem.ack & MEM_MemRead & ~MEM_MemWrite;
  assign memdata = rd_ack ? dmem.rdata : '0;

  assign dmem.req   = req;
  assign dmem.we    = MEM_MemWrite;
  assign dmem.addr  = MEM_ALUOut;
  assign dmem.wdata = MEM_ReadData_2;

  assign mem_stall    = stall;
  assign err_misalign = err_mis_q;
  assign err_timeout  = (state_q == S_ERR);
  assign stall_cycles = stall_cnt_q;

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .pc_i       (MEM_PC),
    .alu_i      (MEM_ALUOut),
    .memdata_i  (memdata),
    .wa_i       (MEM_Write_Address),
    .mtr_i      (MEM_MemtoReg),
    .regwrite_i (MEM_RegWrite & ~misal),
    .pc_o       (WB_PC),
    .alu_o      (WB_ALUOut),
    .memdata_o  (WB_MemData),
    .wa_o       (WB_Write_Address),
    .mtr_o      (WB_MemtoReg),
    .regwrite_o (WB_RegWrite)
  );

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access (TIMEOUT=4).
// Expected WB records are queued at issue and popped after capture.
module tb_mem_stage_access;
  import mem_stage_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_PC, MEM_ALUOut, MEM_ReadData_2;
  logic [4:0]  MEM_Write_Address;
  logic [1:0]  MEM_MemtoReg;
  logic        MEM_MemWrite, MEM_MemRead, MEM_RegWrite;
  logic        mem_stall;
  logic [31:0] WB_PC, WB_ALUOut, WB_MemData;
  logic [4:0]  WB_Write_Address;
  logic [1:0]  WB_MemtoReg;
  logic        WB_RegWrite;
  logic        err_misalign, err_timeout;
  logic [31:0] stall_cycles;

  mem_stage_access_if #(.DATA_W(32)) dm ();

  mem_stage_access #(
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_PC            (MEM_PC),
    .MEM_ALUOut        (MEM_ALUOut),
    .MEM_ReadData_2    (MEM_ReadData_2),
    .MEM_Write_Address (MEM_Write_Address),
    .MEM_MemtoReg      (MEM_MemtoReg),
    .MEM_MemWrite      (MEM_MemWrite),
    .MEM_MemRead       (MEM_MemRead),
    .MEM_RegWrite      (MEM_RegWrite),
    .dmem              (dm.master),
    .mem_stall         (mem_stall),
    .WB_PC             (WB_PC),
    .WB_ALUOut         (WB_ALUOut),
    .WB_MemData        (WB_MemData),
    .WB_Write_Address  (WB_Write_Address),
    .WB_MemtoReg       (WB_MemtoReg),
    .WB_RegWrite       (WB_RegWrite),
    .err_misalign      (err_misalign),
    .err_timeout       (err_timeout),
    .stall_cycles      (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  wa;
    logic [1:0]  mtr;
    logic        rw;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_total = 0;

  int reqc, stallc, bub, hs, badbus;
  bit to;

  function automatic exp_t wb_now();
    exp_t w;
    w.pc  = WB_PC;
    w.alu = WB_ALUOut;
    w.md  = WB_MemData;
    w.wa  = WB_Write_Address;
    w.mtr = WB_MemtoReg;
    w.rw  = WB_RegWrite;
    return w;
  endfunction

  task automatic set_nop();
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_RegWrite = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    set_nop();
    dm.ack   = 1'b0;
    dm.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stall_total = 0;
    sbq.delete();
  endtask

  // Issues one MEM-stage op; ack arrives in cycle lat (0 = never).
  task automatic drive_op(
    input  logic [31:0] pc, alu, wd,
    input  logic [4:0]  wa,
    input  logic [1:0]  mtr,
    input  logic        mw, mr, rw,
    input  int          lat,
    input  logic [31:0] rd,
    input  int          maxc
  );
    exp_t e;
    bit   mis;
    bit   done;
    @(negedge clk);
    MEM_PC = pc; MEM_ALUOut = alu; MEM_ReadData_2 = wd;
    MEM_Write_Address = wa; MEM_MemtoReg = mtr;
    MEM_MemWrite = mw; MEM_MemRead = mr; MEM_RegWrite = rw;
    mis   = (mr | mw) && (alu[1:0] != 2'b00);
    e.pc  = pc;
    e.alu = alu;
    e.md  = (mr && !mw && !mis) ? rd : 32'h0;
    e.wa  = wa;
    e.mtr = mtr;
    e.rw  = rw & ~mis;
    sbq.push_back(e);
    reqc = 0; stallc = 0; bub = 0; hs = 0; badbus = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= maxc && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      dm.ack   = (cyc == lat);
      dm.rdata = (cyc == lat) ? rd : (32'hBAD0_0000 | cyc);
      #1;
      if (dm.req) reqc++;
      if (dm.req && dm.ack) hs++;
      if (dm.req && (dm.we !== mw || dm.addr !== alu
          || dm.wdata !== wd)) badbus++;
      if (mem_stall) stallc++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (!done && WB_RegWrite === 1'b0) bub++;
    end
    to = !done;
    stall_total += stallc;
    dm.ack = 1'b0;
    set_nop();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({dm.req, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_stall got %b want 00", {dm.req, mem_stall});
    end
    checks++;
    if (wb_now() !== '0) begin
      errors++;
      $display("FAIL reset_wb got %h want 0", wb_now());
    end
    checks++;
    if ({err_misalign, err_timeout, stall_cycles} !== 34'h0) begin
      errors++;
      $display("FAIL reset_err_cnt got %b %b %0d want 0 0 0",
               err_misalign, err_timeout, stall_cycles);
    end
  endtask

  task automatic test_zero_wait_load();
    exp_t e;
    drive_op(32'h100, 32'h10, 32'h0, 5'd3, MTR_MEM,
             1'b0, 1'b1, 1'b1, 1, 32'hDEADBEEF, 10);
    checks++;
    if (reqc !== 1 || stallc !== 0 || hs !== 1 || to) begin
      errors++;
      $display("FAIL zw_load req=%0d stall=%0d hs=%0d want 1 0 1",
               reqc, stallc, hs);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL zw_load_wb got %h want %h", wb_now(), e);
    end
  endtask

  task automatic test_store_wait();
    exp_t e;
    drive_op(32'h104, 32'h20, 32'h55, 5'd0, MTR_ALU,
             1'b1, 1'b0, 1'b0, 3, 32'h0, 10);
    checks++;
    if (reqc !== 3 || stallc !== 2 || hs !== 1 || badbus !== 0) begin
      errors++;
      $display("FAIL st3_timing req=%0d stall=%0d hs=%0d bad=%0d want 3 2 1 0",
               reqc, stallc, hs, badbus);
    end
    checks++;
    if (bub !== 2) begin
      errors++;
      $display("FAIL st3_bubble got %0d want 2", bub);
    end
    checks++;
    if (stall_cycles !== stall_total) begin
      errors++;
      $display("FAIL st3_stall_cycles got %0d want %0d",
               stall_cycles, stall_total);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL st3_wb got %h want %h", wb_now(), e);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    checks++;
    if (err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_pre got %b want 0", err_misalign);
    end
    drive_op(32'h108, 32'h13, 32'h0, 5'd7, MTR_MEM,
             1'b0, 1'b1, 1'b1, 1, 32'h1234_5678, 10);
    checks++;
    if (reqc !== 0 || stallc !== 0) begin
      errors++;
      $display("FAIL mis_req req=%0d stall=%0d want 0 0", reqc, stallc);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL mis_wb got %h want %h", wb_now(), e);
    end
    checks++;
    if (err_misalign !== 1'b1) begin
      errors++;
      $display("FAIL mis_pulse got %b want 1", err_misalign);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse_end got %b want 0", err_misalign);
    end
  endtask

  task automatic test_ignored_ack();
    exp_t e;
    drive_op(32'h10C, 32'hABCD_0001, 32'h0, 5'd9, MTR_ALU,
             1'b0, 1'b0, 1'b1, 1, 32'hFEED_FACE, 10);
    checks++;
    if (reqc !== 0 || stallc !== 0) begin
      errors++;
      $display("FAIL alu_req req=%0d stall=%0d want 0 0", reqc, stallc);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL alu_wb got %h want %h", wb_now(), e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_op(32'h200, 32'h40, 32'h0, 5'd12, MTR_MEM,
             1'b0, 1'b1, 1'b1, 2, 32'hCAFE_F00D, 10);
    checks++;
    if (reqc !== 2 || stallc !== 1 || hs !== 1 || bub !== 1) begin
      errors++;
      $display("FAIL b2b_load req=%0d stall=%0d hs=%0d bub=%0d want 2 1 1 1",
               reqc, stallc, hs, bub);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL b2b_load_wb got %h want %h", wb_now(), e);
    end
    drive_op(32'h204, 32'h44, 32'h0BAD_CAFE, 5'd0, MTR_ALU,
             1'b1, 1'b1, 1'b0, 1, 32'h7777_7777, 10);
    checks++;
    if (reqc !== 1 || stallc !== 0 || hs !== 1 || badbus !== 0) begin
      errors++;
      $display("FAIL b2b_store req=%0d stall=%0d hs=%0d bad=%0d want 1 0 1 0",
               reqc, stallc, hs, badbus);
    end
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL b2b_store_wb got %h want %h", wb_now(), e);
    end
    checks++;
    if (stall_cycles !== stall_total) begin
      errors++;
      $display("FAIL b2b_stall_cycles got %0d want %0d",
               stall_cycles, stall_total);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive_op(32'h300, 32'h80, 32'h0, 5'd4, MTR_MEM,
             1'b0, 1'b1, 1'b1, 0, 32'h0, 8);
    checks++;
    if (!to || reqc !== 4 || stallc !== 8) begin
      errors++;
      $display("FAIL to_seq to=%0d req=%0d stall=%0d want 1 4 8",
               to, reqc, stallc);
    end
    checks++;
    if ({err_timeout, dm.req, mem_stall, WB_RegWrite} !== 4'b1010) begin
      errors++;
      $display("FAIL to_state got %b want 1010",
               {err_timeout, dm.req, mem_stall, WB_RegWrite});
    end
    @(negedge clk);
    dm.ack   = 1'b1;
    dm.rdata = 32'h5A5A_5A5A;
    #1;
    checks++;
    if ({dm.req, mem_stall} !== 2'b01) begin
      errors++;
      $display("FAIL to_ack_ignored got %b want 01", {dm.req, mem_stall});
    end
    @(posedge clk);
    #1;
    dm.ack = 1'b0;
    stall_total += 1;
    checks++;
    if (err_timeout !== 1'b1 || stall_cycles !== stall_total) begin
      errors++;
      $display("FAIL to_sticky err=%b cnt=%0d want 1 %0d",
               err_timeout, stall_cycles, stall_total);
    end
    sbq.delete();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    do_reset();
    drive_op(32'h400, 32'h1111_0000, 32'h0, 5'd21, MTR_PC4,
             1'b0, 1'b0, 1'b1, 1, 32'h0, 10);
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e) begin
      errors++;
      $display("FAIL rmw_pre_wb got %h want %h", wb_now(), e);
    end
    drive_op(32'h404, 32'h84, 32'h0, 5'd5, MTR_MEM,
             1'b0, 1'b1, 1'b1, 0, 32'h0, 2);
    sbq.delete();
    @(negedge clk);
    MEM_MemRead = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dm.req, mem_stall, err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL rmw_ctrl got %b want 000",
               {dm.req, mem_stall, err_timeout});
    end
    checks++;
    if (wb_now() !== '0 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL rmw_wb got %h cnt=%0d want 0 0",
               wb_now(), stall_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    stall_total = 0;
    drive_op(32'h408, 32'h88, 32'h0, 5'd6, MTR_MEM,
             1'b0, 1'b1, 1'b1, 2, 32'h0102_0304, 10);
    e = sbq.pop_front();
    checks++;
    if (wb_now() !== e || reqc !== 2 || stallc !== 1) begin
      errors++;
      $display("FAIL rmw_post got %h req=%0d stall=%0d want %h 2 1",
               wb_now(), reqc, stallc, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    MEM_PC = '0; MEM_ALUOut = '0; MEM_ReadData_2 = '0;
    MEM_Write_Address = '0; MEM_MemtoReg = '0;
    set_nop();
    dm.ack = 1'b0;
    dm.rdata = '0;
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_misalign();
    test_ignored_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
